multicycle_ctrl_fsm: RTL
========================

Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle successor to the single-cycle opcode decoder.
- Sequences each RV32 instruction through FETCH/DECODE/EXEC/MEM/WB states with a ready-based memory handshake.
- Adds a parametrised memory-wait timeout, optional JAL support, and a sticky trap state for illegal opcodes and memory timeouts.
- Sits between instruction memory/IR and the datapath; drives all datapath enables and mux selects.

Parameters:
- MEM_TIMEOUT, 255: max cycles waiting on mem_ready before trapping; 0 disables the timeout.
- TIMEOUT_W, 8: wait-counter width; must satisfy MEM_TIMEOUT < 2^TIMEOUT_W.
- ENABLE_JAL, 0: 1 = opcode 7'b1101111 (JAL) is legal; 0 = JAL traps as illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- funct3  in  3  IR[14:12]; passthrough, unused for sequencing.
- funct7  in  7  IR[31:25]; passthrough, unused for sequencing.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held high until mem_ready.
- mem_write  out  1  request is a store.
- ir_write  out  1  load IR.
- pc_write  out  1  PC <= PC+4 (FETCH) or jump target (JAL EXEC).
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded.
- alu_src  out  1  0 = rs2, 1 = immediate.
- mem_to_reg  out  1  1 = writeback from memory.
- reg_write  out  1  register file write enable.
- branch  out  1  branch-resolve strobe.
- link  out  1  writeback selects PC+4 (JAL).
- state  out  3  current state encoding.
- illegal  out  1  sticky: illegal opcode trap.
- timeout  out  1  sticky: memory timeout trap.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Outputs are Moore: decoded from state and op_q. Any output not listed for a state is 0.
- Reset (rst_n low, asynchronous): state=IDLE, op_q=0, wait counter=0, every output 0.
- IDLE: advance to FETCH after one cycle.
- FETCH:
  - mem_req=1, mem_write=0.
  - On mem_ready: ir_write=1 and pc_write=1 in that same cycle (combinational on mem_ready); go to DECODE.
- DECODE:
  - Latch op_q <= opcode.
  - Legal opcodes: 0110011 (R), 0010011 (I), 0000011 (LW), 0100011 (SW), 1100011 (BR), and 1101111 (JAL) only when ENABLE_JAL=1.
  - Legal -> EXEC. Otherwise set illegal=1 and go to TRAP.
- EXEC:
  - R: alu_op=10, alu_src=0 -> WB.
  - I: alu_op=10, alu_src=1 -> WB.
  - LW/SW: alu_op=00, alu_src=1 -> MEM.
  - BR: alu_op=01, alu_src=0, branch=1 for exactly one cycle -> FETCH.
  - JAL: pc_write=1 -> WB.
- MEM:
  - mem_req=1; mem_write=1 for SW.
  - Every signal asserted in the EXEC cycle for LW/SW (alu_op=00, alu_src=1) stays asserted in MEM.
  - On mem_ready: LW -> WB, SW -> FETCH.
- WB:
  - reg_write=1.
  - mem_to_reg=1 for LW.
  - link=1 for JAL.
  - -> FETCH.
- TRAP:
  - All strobes 0; illegal/timeout hold their values.
  - Exit only by reset.
- Wait counter:
  - Clears on entry to FETCH or MEM and increments each cycle mem_ready=0 in those states.
  - If MEM_TIMEOUT!=0 and the counter equals MEM_TIMEOUT with mem_ready=0: set timeout=1, go to TRAP.
  - mem_ready in that same cycle takes priority (normal completion).
- Latency with zero-wait memory (mem_ready high on the first cycle of FETCH/MEM):
  - R/I/SW: 4 cycles, FETCH to next FETCH.
  - LW: 5 cycles.
  - BR: 3 cycles.
  - JAL: 4 cycles.
  - Each memory wait cycle adds 1.
- mem_ready outside FETCH/MEM is ignored.
- Reset asserted mid-instruction aborts immediately; no partial writes after rst_n falls.

Test Plan:
- Reset then R-type (0110011), mem_ready always 1 -> state 0,1,2,3,5,1. reg_write=1 only in WB; alu_op=10 in EXEC; ir_write=pc_write=1 in FETCH.
- LW with mem_ready low for 3 MEM cycles -> MEM lasts 4 cycles with mem_req=1, mem_write=0; then WB with reg_write=1, mem_to_reg=1.
- SW then BR -> SW: MEM mem_write=1, no WB, back to FETCH. BR: EXEC has branch=1, alu_op=01 for one cycle, then FETCH.
- Opcode 1101111 with ENABLE_JAL=0 -> DECODE goes to TRAP, illegal=1 held until rst_n low. With ENABLE_JAL=1 -> EXEC pc_write=1, WB reg_write=1 and link=1.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 5 FETCH cycles, timeout=1. Repeat with mem_ready=1 on the final cycle -> DECODE, no trap.
- rst_n pulsed low during MEM of SW -> mem_req/mem_write drop asynchronously; after release: IDLE then FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32 control sequencer.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with
// memory via mem_ready, and parks in a sticky TRAP state on illegal opcodes
// or when memory fails to answer within MEM_TIMEOUT cycles.
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8,
    parameter int ENABLE_JAL  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       branch,
    output logic       link,
    output logic [2:0] state,
    output logic       illegal,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam bit                   TIMEOUT_EN  = (MEM_TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(MEM_TIMEOUT);
    localparam bit                   JAL_EN      = (ENABLE_JAL != 0);

    state_t               state_reg, state_next;
    logic [6:0]           op_reg, op_next;
    logic [TIMEOUT_W-1:0] wait_reg, wait_next;
    logic                 illegal_reg, illegal_next;
    logic                 timeout_reg, timeout_next;
    logic                 opcode_legal;
    logic                 wait_expired;

    // funct fields are carried alongside the IR for the datapath only
    logic unused_funct;
    assign unused_funct = ^{funct3, funct7};

    // Opcode legality check used in DECODE
    always_comb begin
        opcode_legal = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LW, OP_SW, OP_BR: opcode_legal = 1'b1;
            OP_JAL:                          opcode_legal = JAL_EN;
            default:                         opcode_legal = 1'b0;
        endcase
    end

    // Memory wait has reached its limit (only meaningful while mem_ready is low)
    assign wait_expired = TIMEOUT_EN && (wait_reg == TIMEOUT_VAL);

    // State, latched opcode, wait counter and sticky trap flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            op_reg      <= 7'd0;
            wait_reg    <= '0;
            illegal_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            wait_reg    <= wait_next;
            illegal_reg <= illegal_next;
            timeout_reg <= timeout_next;
        end
    end

    // Next-state and Moore output decode (FETCH strobes also qualify on mem_ready)
    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        wait_next    = wait_reg;
        illegal_next = illegal_reg;
        timeout_next = timeout_reg;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        alu_op       = 2'b00;
        alu_src      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        branch       = 1'b0;
        link         = 1'b0;

        case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_expired) begin
                    timeout_next = 1'b1;
                    state_next   = S_TRAP;
                end else begin
                    wait_next = wait_reg + TIMEOUT_W'(1);
                end
            end
            S_DECODE: begin
                op_next = opcode;
                if (opcode_legal) begin
                    state_next = S_EXEC;
                end else begin
                    illegal_next = 1'b1;
                    state_next   = S_TRAP;
                end
            end
            S_EXEC: begin
                case (op_reg)
                    OP_R: begin
                        alu_op     = 2'b10;
                        state_next = S_WB;
                    end
                    OP_I: begin
                        alu_op     = 2'b10;
                        alu_src    = 1'b1;
                        state_next = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src    = 1'b1;
                        state_next = S_MEM;
                    end
                    OP_BR: begin
                        alu_op     = 2'b01;
                        branch     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write   = 1'b1;
                        state_next = S_WB;
                    end
                    default: begin
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_write = (op_reg == OP_SW);
                alu_src   = 1'b1;
                if (mem_ready) begin
                    state_next = (op_reg == OP_LW) ? S_WB : S_FETCH;
                end else if (wait_expired) begin
                    timeout_next = 1'b1;
                    state_next   = S_TRAP;
                end else begin
                    wait_next = wait_reg + TIMEOUT_W'(1);
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_reg == OP_LW);
                link       = (op_reg == OP_JAL);
                state_next = S_FETCH;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Every fresh memory phase starts counting from zero
        if ((state_next == S_FETCH || state_next == S_MEM) && (state_next != state_reg)) begin
            wait_next = '0;
        end
    end

    assign state   = state_reg;
    assign illegal = illegal_reg;
    assign timeout = timeout_reg;

endmodule
